// File: rtl/hello_uart_tx.sv
// hello_uart_tx: repeats the fixed "hello world\r\n" message on a UART TX line
module hello_uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int REPEAT     = 0,
  parameter int GAP_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       enable,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [3:0] char_idx
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

  state_t        state;
  logic [CW-1:0] baud;
  logic [GW-1:0] gap;
  logic [3:0]    bit_cnt;
  logic [7:0]    cur;
  logic          par_bit;
  logic          bit_end;
  logic          go_on;

  function automatic logic [7:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = 8'h68;
      4'd1:    rom = 8'h65;
      4'd2:    rom = 8'h6C;
      4'd3:    rom = 8'h6C;
      4'd4:    rom = 8'h6F;
      4'd5:    rom = 8'h20;
      4'd6:    rom = 8'h77;
      4'd7:    rom = 8'h6F;
      4'd8:    rom = 8'h72;
      4'd9:    rom = 8'h6C;
      4'd10:   rom = 8'h64;
      4'd11:   rom = 8'h0D;
      default: rom = 8'h0A;
    endcase
  endfunction

  assign cur     = rom(char_idx);
  assign par_bit = ^cur ^ (PARITY == 2);
  assign bit_end = baud == BAUD_LAST;
  assign go_on   = (REPEAT != 0) && enable;

  // Frame sequencer; every output is registered so tx never glitches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      char_idx <= '0;
      baud     <= '0;
      bit_cnt  <= '0;
      gap      <= '0;
    end else begin
      done <= 1'b0;
      baud <= (state == IDLE || state == GAP || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (start || go_on) begin
          state <= START;
          tx    <= 1'b0;
          busy  <= 1'b1;
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_cnt <= '0;
          tx      <= cur[0];
        end
        DATA: if (bit_end) begin
          if (bit_cnt == 4'd7) begin
            state   <= PARITY != 0 ? PAR : STOP;
            tx      <= PARITY != 0 ? par_bit : 1'b1;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            tx      <= cur[bit_cnt[2:0] + 3'd1];
          end
        end
        PAR: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (bit_cnt != STOP_LAST) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (char_idx != 4'd12) begin
            bit_cnt  <= '0;
            char_idx <= char_idx + 4'd1;
            state    <= START;
            tx       <= 1'b0;
          end else begin
            bit_cnt  <= '0;
            char_idx <= '0;
            done     <= 1'b1;
            gap      <= '0;
            state    <= !go_on ? IDLE : (GAP_CYCLES == 0 ? START : GAP);
            tx       <= !(go_on && GAP_CYCLES == 0);
            busy     <= go_on;
          end
        end
        GAP: if (!enable) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (gap == GAP_LAST) begin
          state <= START;
          tx    <= 1'b0;
        end else begin
          gap <= gap + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hello_uart_tx.sv
// tb_hello_uart_tx: directed checks of framing, parity, stop bits, repeat and reset
module tb_hello_uart_tx;
  localparam logic [7:0] MSG [13] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                      8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] start_v = '0;
  logic       en4 = 1'b0;
  logic [4:0] tx_w, busy_w, done_w;
  logic [3:0] idx_w [5];

  logic       tx_log [2000];
  logic       busy_log [2000];
  logic       done_log [2000];
  logic [3:0] idx_log [2000];
  logic [7:0] dec [16];
  int         ndec, nperr;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  hello_uart_tx #(.CLK_DIV(4), .PARITY(0), .STOP_BITS(1), .REPEAT(0), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .enable(1'b1),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .char_idx(idx_w[0]));
  hello_uart_tx #(.CLK_DIV(4), .PARITY(1), .STOP_BITS(1), .REPEAT(0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .enable(1'b1),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .char_idx(idx_w[1]));
  hello_uart_tx #(.CLK_DIV(4), .PARITY(2), .STOP_BITS(1), .REPEAT(0), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .enable(1'b1),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .char_idx(idx_w[2]));
  hello_uart_tx #(.CLK_DIV(4), .PARITY(0), .STOP_BITS(2), .REPEAT(0), .GAP_CYCLES(0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .enable(1'b1),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]), .char_idx(idx_w[3]));
  hello_uart_tx #(.CLK_DIV(4), .PARITY(0), .STOP_BITS(1), .REPEAT(1), .GAP_CYCLES(20)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .enable(en4),
    .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]), .char_idx(idx_w[4]));

  // Pulse start on one DUT, then log its outputs; sample 0 is the cycle after acceptance
  task automatic capture(input int sel, input int len, input int ra, input int rb, input int drop);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    for (int n = 0; n < len; n++) begin
      tx_log[n]   = tx_w[sel];
      busy_log[n] = busy_w[sel];
      done_log[n] = done_w[sel];
      idx_log[n]  = idx_w[sel];
      start_v[sel] = (n == ra || n == rb);
      if (n == drop) en4 = 1'b0;
      @(negedge clk);
    end
    start_v[sel] = 1'b0;
  endtask

  // Recover bytes from the logged line at 4 cycles/bit, sampling mid-bit
  task automatic decode(input int len, input int fb, input int par);
    logic [7:0] b;
    int n;
    n = 0; ndec = 0; nperr = 0;
    while (n + 4 * fb <= len) begin
      if (tx_log[n] == 1'b0) begin
        for (int i = 0; i < 8; i++) b[i] = tx_log[n + 4 * i + 6];
        if (par != 0 && tx_log[n + 38] !== (^b ^ (par == 2))) nperr++;
        if (ndec < 16) dec[ndec] = b;
        ndec++;
        n += 4 * fb;
      end else n++;
    end
  endtask

  function automatic int count_ones(input int which, input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) c += which == 0 ? int'(tx_log[n]) : which == 1 ? int'(busy_log[n]) : int'(done_log[n]);
    return c;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks += 4;
      if (tx_w[i] !== 1'b1) begin n_fail++; $display("FAIL reset_tx[%0d]: got %b expected 1", i, tx_w[i]); end
      if (busy_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy_w[i]); end
      if (done_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", i, done_w[i]); end
      if (idx_w[i] !== 4'd0) begin n_fail++; $display("FAIL reset_idx[%0d]: got %0d expected 0", i, idx_w[i]); end
    end
  endtask

  task automatic test_basic;
    logic [7:0] b;
    int bad;
    capture(0, 600, -1, -1, -1);
    b = MSG[0];
    n_checks++;
    if (count_ones(0, 0, 3) !== 0) begin n_fail++; $display("FAIL start_bit: got %0d high cycles expected 0", count_ones(0, 0, 3)); end
    for (int i = 0; i < 8; i++) begin
      bad = 0;
      for (int n = 4 + 4 * i; n < 8 + 4 * i; n++) if (tx_log[n] !== b[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL data_bit%0d: got %b expected %b", i, tx_log[6 + 4 * i], b[i]); end
    end
    n_checks += 6;
    if (count_ones(0, 36, 39) !== 4 || tx_log[40] !== 1'b0) begin n_fail++; $display("FAIL stop_then_start: got %0d/%b expected 4/0", count_ones(0, 36, 39), tx_log[40]); end
    if (count_ones(1, 0, 599) !== 520) begin n_fail++; $display("FAIL busy_len: got %0d expected 520", count_ones(1, 0, 599)); end
    if (busy_log[519] !== 1'b1 || busy_log[520] !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b%b expected 10", busy_log[519], busy_log[520]); end
    if (count_ones(2, 0, 599) !== 1 || done_log[520] !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %0d/%b expected 1/1", count_ones(2, 0, 599), done_log[520]); end
    if (idx_log[40] !== 4'd1) begin n_fail++; $display("FAIL idx_step: got %0d expected 1", idx_log[40]); end
    decode(600, 10, 0);
    if (ndec != 13) begin n_fail++; $display("FAIL byte_count: got %0d expected 13", ndec); end
    for (int i = 0; i < 13; i++) begin
      n_checks++;
      if (dec[i] !== MSG[i]) begin n_fail++; $display("FAIL byte%0d: got %h expected %h", i, dec[i], MSG[i]); end
    end
  endtask

  task automatic test_parity;
    for (int p = 1; p <= 2; p++) begin
      capture(p, 700, -1, -1, -1);
      n_checks += 4;
      if (tx_log[38] !== (p == 1)) begin n_fail++; $display("FAIL parity%0d_bit: got %b expected %b", p, tx_log[38], p == 1); end
      if (count_ones(1, 0, 699) !== 572) begin n_fail++; $display("FAIL parity%0d_busy: got %0d expected 572", p, count_ones(1, 0, 699)); end
      decode(700, 11, p);
      if (ndec != 13 || nperr != 0) begin n_fail++; $display("FAIL parity%0d_frames: got %0d/%0d expected 13/0", p, ndec, nperr); end
      if (dec[5] !== 8'h20) begin n_fail++; $display("FAIL parity%0d_byte5: got %h expected 20", p, dec[5]); end
    end
  endtask

  task automatic test_stop2;
    int bad = 0;
    capture(3, 700, -1, -1, -1);
    for (int j = 0; j < 12; j++) if (count_ones(0, 44 * j + 36, 44 * j + 43) != 8 || tx_log[44 * j + 44] !== 1'b0) bad++;
    n_checks += 3;
    if (bad != 0) begin n_fail++; $display("FAIL stop2_gap: got %0d bad gaps expected 0", bad); end
    if (count_ones(1, 0, 699) !== 572) begin n_fail++; $display("FAIL stop2_busy: got %0d expected 572", count_ones(1, 0, 699)); end
    decode(700, 11, 0);
    if (ndec != 13) begin n_fail++; $display("FAIL stop2_count: got %0d expected 13", ndec); end
    for (int i = 0; i < 13; i++) begin
      n_checks++;
      if (dec[i] !== MSG[i]) begin n_fail++; $display("FAIL stop2_byte%0d: got %h expected %h", i, dec[i], MSG[i]); end
    end
  endtask

  task automatic test_start_ignored;
    int bad = 0;
    capture(0, 600, 40, 290, -1);
    for (int n = 1; n < 520; n++) if (idx_log[n] < idx_log[n - 1] || idx_log[n] - idx_log[n - 1] > 1) bad++;
    n_checks += 4;
    if (count_ones(2, 0, 599) !== 1) begin n_fail++; $display("FAIL ign_done: got %0d expected 1", count_ones(2, 0, 599)); end
    if (count_ones(1, 0, 599) !== 520) begin n_fail++; $display("FAIL ign_busy: got %0d expected 520", count_ones(1, 0, 599)); end
    if (bad != 0) begin n_fail++; $display("FAIL ign_idx_mono: got %0d steps bad expected 0", bad); end
    if (idx_log[0] !== 4'd0 || idx_log[519] !== 4'd12 || idx_log[520] !== 4'd0) begin n_fail++; $display("FAIL ign_idx_ends: got %0d/%0d/%0d expected 0/12/0", idx_log[0], idx_log[519], idx_log[520]); end
  endtask

  task automatic test_repeat;
    en4 = 1'b1;
    capture(4, 1700, -1, -1, 1290);
    n_checks += 6;
    if (count_ones(2, 0, 1699) !== 3 || done_log[520] !== 1'b1 || done_log[1060] !== 1'b1 || done_log[1600] !== 1'b1) begin
      n_fail++; $display("FAIL rep_done: got %0d pulses %b%b%b expected 3 at 520/1060/1600", count_ones(2, 0, 1699), done_log[520], done_log[1060], done_log[1600]);
    end
    if (busy_log[530] !== 1'b1 || tx_log[530] !== 1'b1) begin n_fail++; $display("FAIL rep_gap: got busy %b tx %b expected 1 1", busy_log[530], tx_log[530]); end
    if (tx_log[539] !== 1'b1 || tx_log[540] !== 1'b0) begin n_fail++; $display("FAIL rep_restart: got %b%b expected 10", tx_log[539], tx_log[540]); end
    if (busy_log[1599] !== 1'b1 || busy_log[1600] !== 1'b0) begin n_fail++; $display("FAIL rep_busy_fall: got %b%b expected 10", busy_log[1599], busy_log[1600]); end
    if (count_ones(1, 1600, 1699) !== 0) begin n_fail++; $display("FAIL rep_stays_idle: got %0d busy cycles expected 0", count_ones(1, 1600, 1699)); end
    if (count_ones(0, 1600, 1699) !== 100) begin n_fail++; $display("FAIL rep_tx_high: got %0d high expected 100", count_ones(0, 1600, 1699)); end
    en4 = 1'b1;
    capture(4, 600, -1, -1, 525);
    n_checks += 2;
    if (busy_log[525] !== 1'b1 || busy_log[526] !== 1'b0) begin n_fail++; $display("FAIL gap_drop_busy: got %b%b expected 10", busy_log[525], busy_log[526]); end
    if (count_ones(0, 520, 599) !== 80 || count_ones(2, 0, 599) !== 1) begin n_fail++; $display("FAIL gap_drop_line: got %0d high/%0d done expected 80/1", count_ones(0, 520, 599), count_ones(2, 0, 599)); end
  endtask

  task automatic test_mid_reset;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (130) @(negedge clk);
    n_checks += 5;
    if (idx_w[0] !== 4'd3) begin n_fail++; $display("FAIL mr_pre_idx: got %0d expected 3", idx_w[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || idx_w[0] !== 4'd0 || done_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL mr_reset: got tx %b busy %b idx %0d done %b expected 1 0 0 0", tx_w[0], busy_w[0], idx_w[0], done_w[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL mr_no_resume: got tx %b busy %b expected 1 0", tx_w[0], busy_w[0]); end
    capture(0, 600, -1, -1, -1);
    decode(600, 10, 0);
    if (ndec != 13 || dec[0] !== 8'h68 || dec[3] !== 8'h6C || dec[12] !== 8'h0A) begin
      n_fail++; $display("FAIL mr_resend: got %0d bytes %h %h %h expected 13 68 6c 0a", ndec, dec[0], dec[3], dec[12]);
    end
    if (count_ones(1, 0, 599) !== 520) begin n_fail++; $display("FAIL mr_busy: got %0d expected 520", count_ones(1, 0, 599)); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_stop2;
    test_start_ignored;
    test_repeat;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
